hack_ctrl: RTL and testbench
============================

HACK_CTRL -- requirements
Module: hack_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set data/address width of all buses and registers.
REQ-002 i_clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 i_rst_n  in  1  reset, SHALL be asynchronous and active-low.
REQ-004 o_imem_addr  out  WIDTH  instruction address (= PC); o_imem_req  out  1  fetch request; i_imem_ack  in  1  fetch done; i_imem_data  in  WIDTH  instruction.
REQ-005 o_dmem_addr  out  WIDTH; o_dmem_wdata  out  WIDTH; o_dmem_we  out  1; o_dmem_req  out  1; i_dmem_ack  in  1; i_dmem_rdata  in  WIDTH; data memory port.
REQ-006 o_alu_a_or_m  out  WIDTH; o_alu_d  out  WIDTH; o_alu_comp  out  6; o_alu_comp_jmp  out  3; i_alu_q  in  WIDTH; i_alu_jmp  in  1; connection to the ALU.
REQ-007 o_pc  out  WIDTH  program counter; o_halt  out  1  halted flag.

Function
REQ-008 Registers: PC, A, D, IR, M (read data), Q (ALU result), T (old A), J (jump flag), all WIDTH except J.
REQ-009 States: BOOT, FETCH, DECODE, MEM_RD, EXEC, MEM_WR, HALT.
REQ-010 BOOT -> FETCH unconditionally after one cycle.
REQ-011 FETCH: o_imem_req=1, o_imem_addr=PC; held until i_imem_ack=1, then IR<=i_imem_data, -> DECODE.
REQ-012 DECODE, IR[15]=0 (A-instr): A<=IR, PC<=PC+1, -> FETCH.
REQ-013 DECODE, IR[15]=1: IR[12]=1 -> MEM_RD; else -> EXEC.
REQ-014 MEM_RD: o_dmem_req=1, o_dmem_we=0, o_dmem_addr=A, held until i_dmem_ack=1, then M<=i_dmem_rdata, -> EXEC.
REQ-015 ALU drive (combinational, all states): o_alu_comp=IR[11:6], o_alu_comp_jmp=IR[2:0], o_alu_d=D, o_alu_a_or_m = IR[12] ? M : A.
REQ-016 EXEC (one cycle): Q<=i_alu_q, J<=i_alu_jmp, T<=A; IR[5]=1 -> A<=i_alu_q; IR[4]=1 -> D<=i_alu_q.
REQ-017 EXEC, IR[3]=0: PC <= i_alu_jmp ? A : PC+1, -> FETCH (jump target is A before this instruction's write).
REQ-018 EXEC, IR[3]=1: PC unchanged, -> MEM_WR.
REQ-019 MEM_WR: o_dmem_req=1, o_dmem_we=1, o_dmem_addr=T, o_dmem_wdata=Q, held until i_dmem_ack=1, then PC <= J ? T : PC+1, -> FETCH.
REQ-020 o_imem_req/o_dmem_req SHALL be 0 in all other states; o_dmem_we=0 except MEM_WR; addr/wdata outputs are don't-care when req=0.
REQ-021 Minimum latency: A-instr 2 cycles, C-instr 3, +1 per memory access; each ack wait adds cycles 1:1.
REQ-022 PC+1 SHALL wrap modulo 2^WIDTH.
REQ-023 An ack arriving in a state without a matching request SHALL be ignored.
REQ-024 IR[14:13] SHALL be ignored for C-instructions.

Reset
REQ-025 While i_rst_n=0: state=BOOT; PC, A, D, IR, M, Q, T, J=0; o_imem_req, o_dmem_req, o_dmem_we, o_halt=0, effective immediately (asynchronous), including mid-transaction.
REQ-026 First fetch SHALL be from address 0, one cycle after reset release.

Configuration
REQ-027 Macro HACK_CTRL_HALT_EN defined: in EXEC, IR[2:0]=111 and A == PC-1 SHALL enter HALT instead of FETCH (PC<=A); HALT is terminal until reset, o_halt=1, no requests.
REQ-028 HACK_CTRL_HALT_EN undefined: HALT state unreachable, o_halt tied 0, jump executes normally.

Verification
REQ-029 Reset release, imem[0]=0x0005, imem[1]=0xEC10 (D=A), ack same cycle -> fetch addrs 0,1; A=5, D=5, PC=2 after 5 cycles.
REQ-030 @100 then 0xFC10 (D=M), i_dmem_rdata=0x1234, ack on 4th cycle of request -> o_dmem_req high 4 cycles, we=0, addr=100, D=0x1234.
REQ-031 @7 then 0xEDE8 (AM=A+1) -> one write, addr=7, wdata=8, we=1; A=8 afterwards; PC=2.
REQ-032 @10 then 0xE301 (D;JGT): D=0 -> PC=2; D=1 -> PC=10.
REQ-033 HACK_CTRL_HALT_EN defined, imem[6]=0x0006, imem[7]=0xEA87 (0;JMP) -> o_halt=1, o_imem_req stays 0; undefined -> fetch addrs loop 6,7,6,7.
REQ-034 i_rst_n pulled low during MEM_RD with ack withheld -> o_dmem_req=0 same cycle, on release fetch from address 0.

Source files
------------

// File: rtl/hack_ctrl_if.sv
`default_nettype none
// ============================================================================
// hack_ctrl_if : instruction, data-memory and ALU buses of the Hack controller
// Rev 1.0
// ============================================================================
interface hack_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] o_imem_addr;
    logic             o_imem_req;
    logic             i_imem_ack;
    logic [WIDTH-1:0] i_imem_data;

    logic [WIDTH-1:0] o_dmem_addr;
    logic [WIDTH-1:0] o_dmem_wdata;
    logic             o_dmem_we;
    logic             o_dmem_req;
    logic             i_dmem_ack;
    logic [WIDTH-1:0] i_dmem_rdata;

    logic [WIDTH-1:0] o_alu_a_or_m;
    logic [WIDTH-1:0] o_alu_d;
    logic [5:0]       o_alu_comp;
    logic [2:0]       o_alu_comp_jmp;
    logic [WIDTH-1:0] i_alu_q;
    logic             i_alu_jmp;

    modport master (
        output o_imem_addr, o_imem_req,
        input  i_imem_ack, i_imem_data,
        output o_dmem_addr, o_dmem_wdata, o_dmem_we, o_dmem_req,
        input  i_dmem_ack, i_dmem_rdata,
        output o_alu_a_or_m, o_alu_d, o_alu_comp, o_alu_comp_jmp,
        input  i_alu_q, i_alu_jmp
    );

    modport slave (
        input  o_imem_addr, o_imem_req,
        output i_imem_ack, i_imem_data,
        input  o_dmem_addr, o_dmem_wdata, o_dmem_we, o_dmem_req,
        output i_dmem_ack, i_dmem_rdata,
        input  o_alu_a_or_m, o_alu_d, o_alu_comp, o_alu_comp_jmp,
        output i_alu_q, i_alu_jmp
    );
endinterface
`default_nettype wire

// File: rtl/hack_ctrl.sv
`default_nettype none
// ============================================================================
// hack_ctrl : multi-cycle Hack CPU controller (fetch/decode/exec, external ALU)
// Optional macro HACK_CTRL_HALT_EN: a jump back to the previous instruction
// halts the core until reset.                                          Rev 1.0
// ============================================================================
module hack_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    hack_ctrl_if.master      bus,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_halt
);

    localparam logic [2:0] S_BOOT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_MEM_RD = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_MEM_WR = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic             j_q, j_d;

    logic [WIDTH-1:0] pc_inc;
    logic             halt_hit;

    assign pc_inc = pc_q + ONE;

`ifdef HACK_CTRL_HALT_EN
    // "@(PC-1); 0;JMP" is the idiomatic end-of-program spin loop
    assign halt_hit = (ir_q[2:0] == 3'b111) && (a_q == (pc_q - ONE));
`else
    assign halt_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= '0;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            m_q     <= '0;
            q_q     <= '0;
            t_q     <= '0;
            j_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            m_q     <= m_d;
            q_q     <= q_d;
            t_q     <= t_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        d_d     = d_q;
        ir_d    = ir_q;
        m_d     = m_q;
        q_d     = q_q;
        t_d     = t_q;
        j_d     = j_q;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.i_imem_ack) begin
                    ir_d    = bus.i_imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir_q[15]) begin
                    a_d     = ir_q;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else if (ir_q[12]) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEM_RD: begin
                if (bus.i_dmem_ack) begin
                    m_d     = bus.i_dmem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                q_d = bus.i_alu_q;
                j_d = bus.i_alu_jmp;
                t_d = a_q;
                if (ir_q[5]) a_d = bus.i_alu_q;
                if (ir_q[4]) d_d = bus.i_alu_q;
                // jump target is always the A value from before this write
                if (ir_q[3]) begin
                    state_d = S_MEM_WR;
                end else if (halt_hit) begin
                    pc_d    = a_q;
                    state_d = S_HALT;
                end else begin
                    pc_d    = bus.i_alu_jmp ? a_q : pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_MEM_WR: begin
                if (bus.i_dmem_ack) begin
                    pc_d    = j_q ? t_q : pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        bus.o_imem_req     = (state_q == S_FETCH);
        bus.o_imem_addr    = pc_q;
        bus.o_dmem_req     = (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        bus.o_dmem_we      = (state_q == S_MEM_WR);
        bus.o_dmem_addr    = (state_q == S_MEM_WR) ? t_q : a_q;
        bus.o_dmem_wdata   = q_q;
        bus.o_alu_comp     = ir_q[11:6];
        bus.o_alu_comp_jmp = ir_q[2:0];
        bus.o_alu_d        = d_q;
        bus.o_alu_a_or_m   = ir_q[12] ? m_q : a_q;
        o_pc               = pc_q;
`ifdef HACK_CTRL_HALT_EN
        o_halt             = (state_q == S_HALT);
`else
        o_halt             = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_hack_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hack_ctrl : instruction-level Hack model + randomized memory slaves
// Rev 1.0
// ============================================================================
module tb_hack_ctrl;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pc;
    logic         halt;

    always #5 clk = ~clk;

    hack_ctrl_if #(.WIDTH(W)) bus ();

    hack_ctrl #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_pc    (pc),
        .o_halt  (halt)
    );

    // Hack ALU: x=D, y=A|M, comp bits zx nx zy ny f no; jump bits lt eq gt
    function automatic logic [15:0] alu_f(input logic [15:0] x_in, input logic [15:0] y_in,
                                          input logic [5:0] c);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] r;
        x = c[5] ? 16'h0 : x_in;
        if (c[4]) x = ~x;
        y = c[3] ? 16'h0 : y_in;
        if (c[2]) y = ~y;
        r = c[1] ? x + y : x & y;
        if (c[0]) r = ~r;
        return r;
    endfunction

    function automatic logic jmp_f(input logic [15:0] r, input logic [2:0] j);
        return (j[2] && r[15]) || (j[1] && r == 16'h0) || (j[0] && !r[15] && r != 16'h0);
    endfunction

    assign bus.i_alu_q   = alu_f(bus.o_alu_d, bus.o_alu_a_or_m, bus.o_alu_comp);
    assign bus.i_alu_jmp = jmp_f(bus.i_alu_q, bus.o_alu_comp_jmp);

    logic [15:0] imem     [65536];
    logic [15:0] dmem     [65536];
    logic [15:0] mdl_dmem [65536];

    typedef struct packed {
        logic [1:0]  kind;   // 0 fetch, 1 read, 2 write
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t expq[$];

    logic [15:0] m_a, m_d, m_pc;
    logic        m_halt;

    logic [15:0] flog[$];
    logic [15:0] dlog[$];
    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];
    logic [15:0] rd_addr[$];
    int          rd_len[$];
    int          fetch_cnt;
    int          i_fix = -1;
    int          d_fix = -1;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input int fix);
        return (fix < 0) ? int'($urandom_range(0, 3)) : fix;
    endfunction

    // Architectural step: queue the bus traffic this instruction must produce
    task automatic mdl_step(input logic [15:0] ins);
        logic [15:0] y;
        logic [15:0] r;
        logic [15:0] olda;
        logic        jb;
        if (!ins[15]) begin
            m_a  = ins;
            m_pc = m_pc + 16'd1;
            expq.push_back('{2'd0, m_pc, 16'h0});
        end else begin
            olda = m_a;
            if (ins[12]) begin
                y = mdl_dmem[m_a];
                expq.push_back('{2'd1, m_a, 16'h0});
            end else begin
                y = m_a;
            end
            r  = alu_f(m_d, y, ins[11:6]);
            jb = jmp_f(r, ins[2:0]);
            if (ins[5]) m_a = r;
            if (ins[4]) m_d = r;
            if (ins[3]) begin
                expq.push_back('{2'd2, olda, r});
                mdl_dmem[olda] = r;
            end
`ifdef HACK_CTRL_HALT_EN
            if (!ins[3] && ins[2:0] == 3'b111 && olda == m_pc - 16'd1) begin
                m_pc   = olda;
                m_halt = 1'b1;
            end else
`endif
            begin
                m_pc = jb ? olda : m_pc + 16'd1;
                expq.push_back('{2'd0, m_pc, 16'h0});
            end
        end
    endtask

    // Memory slaves plus the single compare point, half a cycle off the edge
    initial begin : bus_side
        int   i_cnt;
        int   i_dly;
        int   d_cnt;
        int   d_dly;
        int   d_len;
        logic ok;
        exp_t e;
        i_cnt = 0; i_dly = 0; d_cnt = 0; d_dly = 0; d_len = 0;
        bus.i_imem_ack = 1'b0; bus.i_imem_data = '0;
        bus.i_dmem_ack = 1'b0; bus.i_dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.i_imem_ack = 1'b0;
                bus.i_dmem_ack = 1'b0;
                i_cnt = 0; d_cnt = 0; d_len = 0;
                i_dly = pick(i_fix);
                d_dly = pick(d_fix);
                continue;
            end
            bus.i_imem_data = 16'($urandom);
            bus.i_dmem_rdata = 16'($urandom);
            if (bus.o_imem_req) begin
                if (i_cnt >= i_dly) begin
                    bus.i_imem_ack  = 1'b1;
                    bus.i_imem_data = imem[bus.o_imem_addr];
                    i_cnt = 0;
                    i_dly = pick(i_fix);
                end else begin
                    bus.i_imem_ack = 1'b0;
                    i_cnt++;
                end
            end else begin
                bus.i_imem_ack = ($urandom_range(0, 3) == 0);
            end
            if (bus.o_dmem_req) begin
                d_len++;
                if (d_cnt >= d_dly) begin
                    bus.i_dmem_ack   = 1'b1;
                    bus.i_dmem_rdata = dmem[bus.o_dmem_addr];
                    d_cnt = 0;
                    d_dly = pick(d_fix);
                end else begin
                    bus.i_dmem_ack = 1'b0;
                    d_cnt++;
                end
            end else begin
                bus.i_dmem_ack = ($urandom_range(0, 3) == 0);
            end
            #1;
            chk("req_exclusive", 32'(bus.o_imem_req && bus.o_dmem_req), 0);
            chk("we_without_req", 32'(bus.o_dmem_we && !bus.o_dmem_req), 0);
`ifdef HACK_CTRL_HALT_EN
            if (halt) chk("halt_quiet", {bus.o_imem_req, bus.o_dmem_req, m_halt}, 32'b001);
`else
            chk("halt_tied_low", 32'(halt), 0);
`endif
            if (bus.o_imem_req && bus.i_imem_ack) begin
                fetch_cnt++;
                flog.push_back(bus.o_imem_addr);
                dlog.push_back(bus.o_alu_d);
                ok = (expq.size() > 0) && (expq[0].kind == 2'd0);
                chk("fetch_order", 32'(ok), 1);
                if (ok) begin
                    e = expq.pop_front();
                    chk("fetch_addr", bus.o_imem_addr, e.addr);
                    chk("pc_out", pc, e.addr);
                    chk("d_at_fetch", bus.o_alu_d, m_d);
                    mdl_step(imem[e.addr]);
                end
            end
            if (bus.o_dmem_req && bus.i_dmem_ack) begin
                ok = (expq.size() > 0) && (expq[0].kind == (bus.o_dmem_we ? 2'd2 : 2'd1));
                chk("dmem_order", 32'(ok), 1);
                if (ok) begin
                    e = expq.pop_front();
                    chk("dmem_addr", bus.o_dmem_addr, e.addr);
                    if (bus.o_dmem_we) chk("dmem_wdata", bus.o_dmem_wdata, e.data);
                end
                if (bus.o_dmem_we) begin
                    dmem[bus.o_dmem_addr] = bus.o_dmem_wdata;
                    wr_addr.push_back(bus.o_dmem_addr);
                    wr_data.push_back(bus.o_dmem_wdata);
                end else begin
                    rd_addr.push_back(bus.o_dmem_addr);
                    rd_len.push_back(d_len);
                end
                d_len = 0;
            end
        end
    end

    task automatic enter_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            imem[i] = 16'h0; dmem[i] = 16'h0; mdl_dmem[i] = 16'h0;
        end
    endtask

    task automatic poke_d(input logic [15:0] a, input logic [15:0] v);
        dmem[a] = v;
        mdl_dmem[a] = v;
    endtask

    task automatic start();
        expq.delete(); flog.delete(); dlog.delete();
        wr_addr.delete(); wr_data.delete(); rd_addr.delete(); rd_len.delete();
        m_a = 16'h0; m_d = 16'h0; m_pc = 16'h0; m_halt = 1'b0; fetch_cnt = 0;
        expq.push_back('{2'd0, 16'h0, 16'h0});
        @(negedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_fetches(input int n, input string nm);
        int cyc;
        cyc = 0;
        while (fetch_cnt < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        #2;
        chk(nm, 32'(fetch_cnt >= n), 1);
    endtask

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : seq
        // reset state and first fetch from 0 one cycle after release
        clear_mem();
        imem[0] = 16'h0005; imem[1] = 16'hEC10;
        i_fix = 0; d_fix = 0;
        #17;
        chk("rst_outputs", {bus.o_imem_req, bus.o_dmem_req, bus.o_dmem_we, halt}, 0);
        chk("rst_pc", pc, 0);
        start();
        @(negedge clk); #2;
        chk("first_fetch", {bus.o_imem_req, bus.o_imem_addr}, {1'b1, 16'h0000});
        wait_fetches(3, "t029_progress");
        chk("t029_fetch0", flog[0], 16'h0000);
        chk("t029_fetch1", flog[1], 16'h0001);
        chk("t029_pc2", flog[2], 16'h0002);
        chk("t029_d", dlog[2], 16'h0005);

        // D=M with ack on the 4th request cycle
        enter_reset(); clear_mem();
        imem[0] = 16'h0064; imem[1] = 16'hFC10; poke_d(16'd100, 16'h1234);
        d_fix = 3;
        start();
        wait_fetches(3, "t030_progress");
        chk("t030_rd_addr", rd_addr[0], 16'd100);
        chk("t030_rd_len", 32'(rd_len[0]), 4);
        chk("t030_d", dlog[2], 16'h1234);
        chk("t030_no_writes", 32'(wr_addr.size()), 0);

        // AM=A+1
        enter_reset(); clear_mem();
        imem[0] = 16'h0007; imem[1] = 16'hEDE8; imem[2] = 16'hEC10;
        i_fix = -1; d_fix = -1;
        start();
        wait_fetches(4, "t031_progress");
        chk("t031_wr_count", 32'(wr_addr.size()), 1);
        chk("t031_wr_addr", wr_addr[0], 16'd7);
        chk("t031_wr_data", wr_data[0], 16'd8);
        chk("t031_pc", flog[2], 16'd2);
        chk("t031_a", dlog[3], 16'd8);

        // D;JGT not taken with D=0, taken with D=1
        enter_reset(); clear_mem();
        imem[0] = 16'h000A; imem[1] = 16'hE301;
        start();
        wait_fetches(3, "t032a_progress");
        chk("t032_not_taken", flog[2], 16'd2);
        enter_reset(); clear_mem();
        imem[0] = 16'h0001; imem[1] = 16'hEC10; imem[2] = 16'h000A; imem[3] = 16'hE301;
        start();
        wait_fetches(5, "t032b_progress");
        chk("t032_taken", flog[4], 16'd10);

        // PC wraps from 0xFFFF to 0
        enter_reset(); clear_mem();
        imem[0] = 16'hEEA0; imem[1] = 16'hEA87; imem[16'hFFFF] = 16'h0003;
        start();
        wait_fetches(4, "wrap_progress");
        chk("wrap_jump", flog[2], 16'hFFFF);
        chk("wrap_to_zero", flog[3], 16'h0000);

        // jump to previous instruction: halt or spin
        enter_reset(); clear_mem();
        imem[6] = 16'h0006; imem[7] = 16'hEA87;
        start();
`ifdef HACK_CTRL_HALT_EN
        wait_fetches(8, "t033_progress");
        repeat (20) @(negedge clk);
        #2;
        chk("t033_halt", {halt, bus.o_imem_req, bus.o_dmem_req}, 3'b100);
        chk("t033_fetch_count", 32'(fetch_cnt), 8);
        chk("t033_pc", pc, 16'd6);
`else
        wait_fetches(10, "t033_progress");
        chk("t033_loop6", flog[8], 16'd6);
        chk("t033_loop7", flog[9], 16'd7);
        chk("t033_no_halt", 32'(halt), 0);
`endif

        // async reset while a read is stalled
        enter_reset(); clear_mem();
        imem[0] = 16'h0064; imem[1] = 16'hFC10;
        d_fix = 30;
        start();
        for (int c = 0; c < 50 && !bus.o_dmem_req; c++) @(negedge clk);
        chk("t034_in_mem_rd", 32'(bus.o_dmem_req), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t034_req_drop", {bus.o_dmem_req, bus.o_imem_req, bus.o_dmem_we}, 0);
        chk("t034_pc_zero", pc, 0);
        d_fix = -1;
        start();
        @(negedge clk); #2;
        chk("t034_refetch0", {bus.o_imem_req, bus.o_imem_addr}, {1'b1, 16'h0000});

        // random programs, random ack latency, spurious acks
        for (int r = 0; r < 2; r++) begin
            enter_reset();
            for (int i = 0; i < 65536; i++) begin
                if ($urandom_range(0, 2) == 0) imem[i] = {1'b0, 15'($urandom_range(0, 63))};
                else imem[i] = {3'b111, 13'($urandom)};
                dmem[i] = 16'($urandom);
                mdl_dmem[i] = dmem[i];
            end
            start();
            repeat (3000) @(negedge clk);
            #2;
            chk("random_progress", 32'(fetch_cnt > 100 || m_halt), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
